issue_queue: RTL
================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; power of two, at least 2.
REQ-002 Parameter INFO_DW, default 64, width of the opaque micro-op payload.
REQ-003 Parameter RNBIT, default 2, rename bits per architectural register; RNDEPTH = 2**RNBIT.
REQ-004 CLK  input  1  clock; all state on rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 dispat_valid  input  1  dispatch offers one micro-op.
REQ-007 dispat_ready  output  1  queue accepts the micro-op this cycle.
REQ-008 dispat_info  input  INFO_DW  micro-op payload.
REQ-009 dispat_rs1, dispat_rs2  input  5+RNBIT each  physical source indices.
REQ-010 dispat_rs1_need, dispat_rs2_need  input  1 each  source is read by the op.
REQ-011 wb_status  input  32*RNDEPTH  bit p = physical register p written back.
REQ-012 execute_valid  output  1  a ready micro-op is offered.
REQ-013 execute_ready  input  1  execute unit takes it.
REQ-014 execute_info  output  INFO_DW  payload of selected entry.
REQ-015 execute_rs1, execute_rs2  output  5+RNBIT each  source indices of selected entry.
REQ-016 flush  input  1  discard all entries.
REQ-017 count  output  $clog2(DEPTH)+1  occupied entries.

Function
- REQ-018 Storage is a compacting shift buffer: entry 0 is oldest; valid entries always occupy indices 0..count-1.
- REQ-019 Entry i is ready when valid and (~rs1_need | wb_status[rs1]) and (~rs2_need | wb_status[rs2]), evaluated combinationally every cycle.
- REQ-020 Selection picks the lowest-index ready entry (oldest-first).
- REQ-021 execute_valid = any ready entry; execute_info/rs1/rs2 come from the selected entry; outputs are 0 when execute_valid is low.
- REQ-022 Issue fire = execute_valid & execute_ready; on fire, entries above the selected index shift down one place at the next edge.
- REQ-023 dispat_ready = (count != DEPTH); it depends only on registered state, with no combinational path from execute_ready.
- REQ-024 Push fire = dispat_valid & dispat_ready; the new entry is written at index count, or at count-1 when issue fires in the same cycle.
- REQ-025 count increments on push only, decrements on issue only, and is unchanged on push+issue.
- REQ-026 Zero-latency wakeup is not provided: an entry pushed in cycle N is first eligible in cycle N+1.
- REQ-027 flush high: all valid bits and count clear at the next edge; push and issue in that cycle are discarded; execute_valid stays combinationally valid but its fire is ignored.
- REQ-028 Full + issue in the same cycle: dispat_ready stays 0 that cycle (no bypass).
- REQ-029 Empty: execute_valid = 0 regardless of wb_status.
- REQ-030 wb_status is only sampled; the queue never writes the scoreboard.

Reset
- REQ-031 RST high at an edge: all valid bits 0 and count 0; payload registers need not be cleared.
- REQ-032 In the cycle after reset: dispat_ready 1, execute_valid 0, execute_info/rs1/rs2 0.
- REQ-033 Reset asserted mid-operation overrides flush, push and issue in the same cycle.

Structure
- REQ-034 DEPTH/INFO_DW/RNBIT defaults and the per-entry record layout (info, rs1, rs2, need flags) SHALL live in the shared backend parameter package.
- REQ-035 A sub-module issue_pick (DEPTH-wide lowest-set-bit priority encoder with index and any outputs) SHALL implement REQ-020.
- REQ-036 Compaction shift and push write SHALL be in a single clocked process per entry.

Verification
- REQ-037 Reset then push 4 ops (DEPTH=4), all needs 0 -> count=4, dispat_ready=0; with execute_ready=1 they issue in push order over 4 cycles.
- REQ-038 Push A (rs1=p5 not ready) then B (ready) -> B issues first; set wb_status[5] -> A issues next cycle; count returns to 0.
- REQ-039 Queue full, entry 2 ready, push offered -> entry 2 issues, entries 3 shift to 2, dispat_ready 0 that cycle and 1 the next; count=3.
- REQ-040 count=2, push and issue same cycle -> count stays 2; new op lands at index 1.
- REQ-041 count=3, flush with push and issue -> next cycle count=0, execute_valid=0, the pushed op is never issued.
- REQ-042 RST asserted mid-stream with execute_ready=1 -> no further issue; count=0 the next cycle.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Backend parameters shared by the issue queue and its helpers.
// Holds the default sizes and the layout of one queue entry.
package issue_queue_pkg;

    localparam int IQ_DEPTH   = 4;
    localparam int IQ_INFO_DW = 64;
    localparam int IQ_RNBIT   = 2;
    localparam int IQ_RW      = 5 + IQ_RNBIT;

    // One stored micro-op: payload, physical sources and which sources it reads.
    // The field widths follow the defaults above, so a different configuration
    // is made by changing them here rather than by overriding the top parameters.
    typedef struct packed {
        logic [IQ_INFO_DW-1:0] info;
        logic [IQ_RW-1:0]      rs1;
        logic [IQ_RW-1:0]      rs2;
        logic                  rs1_need;
        logic                  rs2_need;
    } iq_entry_t;

endpackage

// File: rtl/issue_pick.sv
// Lowest-set-bit priority encoder: index 0 holds the oldest entry,
// so the lowest ready index is the oldest ready micro-op.
module issue_pick #(
    parameter int DEPTH = 4,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req,
    output logic [IW-1:0]    idx,
    output logic             any
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Oldest-first issue queue built as a compacting shift buffer.
// Valid entries always sit in slots 0..count-1; an issued entry is closed
// up by shifting everything above it down one slot.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH   = IQ_DEPTH,
    parameter int INFO_DW = IQ_INFO_DW,
    parameter int RNBIT   = IQ_RNBIT,
    localparam int RW      = 5 + RNBIT,
    localparam int RNDEPTH = 2 ** RNBIT,
    localparam int IW      = $clog2(DEPTH),
    localparam int CW      = IW + 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 dispat_valid,
    output logic                 dispat_ready,
    input  logic [INFO_DW-1:0]   dispat_info,
    input  logic [RW-1:0]        dispat_rs1,
    input  logic [RW-1:0]        dispat_rs2,
    input  logic                 dispat_rs1_need,
    input  logic                 dispat_rs2_need,
    input  logic [32*RNDEPTH-1:0] wb_status,
    output logic                 execute_valid,
    input  logic                 execute_ready,
    output logic [INFO_DW-1:0]   execute_info,
    output logic [RW-1:0]        execute_rs1,
    output logic [RW-1:0]        execute_rs2,
    input  logic                 flush,
    output logic [CW-1:0]        count
);

    iq_entry_t        ent_q   [DEPTH];
    logic             valid_q [DEPTH];
    logic [DEPTH-1:0] ready;
    logic [IW-1:0]    sel;
    logic             any;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    wpos;
    logic             issue_fire;
    logic             push_fire;
    iq_entry_t        ent_new;

    // Wakeup: an entry is eligible once every source it reads has been written back.
    always_comb begin
        ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = valid_q[i]
                     & (~ent_q[i].rs1_need | wb_status[ent_q[i].rs1])
                     & (~ent_q[i].rs2_need | wb_status[ent_q[i].rs2]);
        end
    end

    issue_pick #(.DEPTH(DEPTH)) u_pick (
        .req (ready),
        .idx (sel),
        .any (any)
    );

    // Full is judged on registered count only, so a same-cycle issue never frees a slot.
    assign dispat_ready = (count_q != CW'(DEPTH));
    assign issue_fire   = any & execute_ready & ~flush;
    assign push_fire    = dispat_valid & dispat_ready & ~flush;
    // With a simultaneous issue the buffer closes up, so the new op lands one slot lower.
    assign wpos         = issue_fire ? count_q - CW'(1) : count_q;
    assign count        = count_q;

    // Pack the dispatched op into the stored entry format.
    always_comb begin
        ent_new          = '0;
        ent_new.info     = dispat_info;
        ent_new.rs1      = dispat_rs1;
        ent_new.rs2      = dispat_rs2;
        ent_new.rs1_need = dispat_rs1_need;
        ent_new.rs2_need = dispat_rs2_need;
    end

    // Present the selected entry; outputs are forced to zero when nothing is ready.
    always_comb begin
        execute_valid = any;
        execute_info  = '0;
        execute_rs1   = '0;
        execute_rs2   = '0;
        if (any) begin
            execute_info = ent_q[sel].info;
            execute_rs1  = ent_q[sel].rs1;
            execute_rs2  = ent_q[sel].rs2;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic      shift;
        logic      nxt_valid;
        iq_entry_t nxt_ent;

        assign shift = issue_fire && (CW'(i) >= CW'(sel));

        if (i == DEPTH - 1) begin : g_top
            assign nxt_valid = 1'b0;
            assign nxt_ent   = ent_q[i];
        end else begin : g_mid
            assign nxt_valid = valid_q[i+1];
            assign nxt_ent   = ent_q[i+1];
        end

        // Per-slot update: a push into this slot wins over the shift from above.
        always_ff @(posedge CLK) begin
            if (RST || flush) begin
                valid_q[i] <= 1'b0;
            end else if (push_fire && wpos == CW'(i)) begin
                valid_q[i] <= 1'b1;
                ent_q[i]   <= ent_new;
            end else if (shift) begin
                valid_q[i] <= nxt_valid;
                ent_q[i]   <= nxt_ent;
            end
        end
    end

    // Occupancy: push and issue together leave the count unchanged.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            count_q <= '0;
        end else begin
            case ({push_fire, issue_fire})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
